instr_readback_checker: RTL and testbench

- Downstream consumer of the instruction register. Walks `read_pointer` over a programmed address window and captures each `instruction_word`.
- Recomputes the expected result from opcode and operands and flags mismatches.
- Streams each captured word plus its check verdict out over a valid/ready interface to the scoreboard/monitor side.

---
 rtl/instr_register_pkg.sv | 70 +++++++
 rtl/instr_result_calc.sv | 17 +
 rtl/instr_readback_checker.sv | 155 +++++++++++++++
 tb/tb_instr_readback_checker.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its consumers.
// Holds the opcode/operand/result/address types, the instruction word layout,
// the readback FSM state type and the reference result calculation
// (calc_expected), which the register scoreboard also uses.
package instr_register_pkg;

    localparam int unsigned OPERAND_W = 32;
    localparam int unsigned RESULT_W  = 64;
    localparam int unsigned ADDR_W    = 5;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [OPERAND_W-1:0] operand_t;
    typedef logic signed [RESULT_W-1:0]  result_t;
    typedef logic        [ADDR_W-1:0]    address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  res;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } readback_state_t;

    // Operands are sign-extended to the result width before the operation.
    // Division and modulo by zero, and unknown opcodes, yield 0.
    function automatic result_t calc_expected(opcode_t opcode, operand_t a, operand_t b);
        result_t ax;
        result_t bx;
        result_t res;
        ax  = {{(RESULT_W-OPERAND_W){a[OPERAND_W-1]}}, a};
        bx  = {{(RESULT_W-OPERAND_W){b[OPERAND_W-1]}}, b};
        res = '0;
        case (opcode)
            ZERO:  res = '0;
            PASSA: res = ax;
            PASSB: res = bx;
            ADD:   res = ax + bx;
            SUB:   res = ax - bx;
            MULT:  res = ax * bx;
            // if/else rather than ?: so the '0 branch cannot make the divide unsigned
            DIV: begin
                if (bx == '0) res = '0;
                else          res = ax / bx;
            end
            MOD: begin
                if (bx == '0) res = '0;
                else          res = ax % bx;
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/instr_result_calc.sv
// Combinational expected-result calculator.
// Ports: opcode_i/op_a_i/op_b_i - decoded fields of an instruction word;
//        result_o - result the instruction should have stored.
module instr_result_calc
    import instr_register_pkg::*;
(
    input  opcode_t  opcode_i,
    input  operand_t op_a_i,
    input  operand_t op_b_i,
    output result_t  result_o
);

    always_comb begin
        result_o = calc_expected(opcode_i, op_a_i, op_b_i);
    end

endmodule

// File: rtl/instr_readback_checker.sv
// Instruction register readback checker.
// Walks read_pointer from first_ptr to last_ptr (inclusive, modulo 32),
// captures each instruction_word, compares its stored result against the
// recomputed one and streams {word, address, mismatch} over valid/ready.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start, abort        - begin a pass (ignored while busy) / terminate a pass
//   first_ptr, last_ptr - address window, last inclusive
//   instruction_word    - combinational register read data at read_pointer
//   read_pointer        - registered read address
//   out_valid/out_ready - output handshake for out_instr/out_addr/out_mismatch
//   busy, done          - pass in progress / one-cycle end-of-pass pulse
//   err_count           - saturating mismatch count since reset
module instr_readback_checker
    import instr_register_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  address_t             first_ptr,
    input  address_t             last_ptr,
    input  instruction_t         instruction_word,
    output address_t             read_pointer,
    output logic                 out_valid,
    input  logic                 out_ready,
    output instruction_t         out_instr,
    output address_t             out_addr,
    output logic                 out_mismatch,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_count
);

    readback_state_t      state_q, state_d;
    address_t             ptr_q, ptr_d;
    address_t             last_q, last_d;
    logic                 out_valid_q, out_valid_d;
    instruction_t         out_instr_q, out_instr_d;
    address_t             out_addr_q, out_addr_d;
    logic                 out_mismatch_q, out_mismatch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    result_t expected;
    logic    mismatch;

    instr_result_calc u_calc (
        .opcode_i (instruction_word.opc),
        .op_a_i   (instruction_word.op_a),
        .op_b_i   (instruction_word.op_b),
        .result_o (expected)
    );

    assign mismatch = (instruction_word.res != expected);

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        last_d         = last_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_addr_d     = out_addr_q;
        out_mismatch_d = out_mismatch_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_count_d    = err_count_q;

        // abort beats everything outside IDLE, including a pending handshake
        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        ptr_d   = first_ptr;
                        last_d  = last_ptr;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    // read_pointer was set on the previous edge, so the word is valid now
                    out_instr_d    = instruction_word;
                    out_addr_d     = ptr_q;
                    out_mismatch_d = mismatch;
                    out_valid_d    = 1'b1;
                    if (mismatch && (err_count_q != '1)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    state_d = SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        if (ptr_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            ptr_d   = ptr_q + 1'b1;  // wraps 31 -> 0
                            state_d = FETCH;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            last_q         <= '0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_addr_q     <= '0;
            out_mismatch_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            last_q         <= last_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_addr_q     <= out_addr_d;
            out_mismatch_q <= out_mismatch_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_count_q    <= err_count_d;
        end
    end

    // read_pointer and the walking pointer are the same register
    assign read_pointer = ptr_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_addr     = out_addr_q;
    assign out_mismatch = out_mismatch_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_instr_readback_checker.sv
// Bench for instr_readback_checker: a behavioural register array feeds
// instruction_word; expected entries are queued when a pass is launched and
// popped as the DUT presents them. A 2-bit error counter exposes saturation.
module tb_instr_readback_checker;
    import instr_register_pkg::*;

    localparam int unsigned ErrW = 2;

    logic            clk = 1'b0;
    logic            reset, start, abort, out_ready;
    address_t        first_ptr, last_ptr, read_pointer, out_addr;
    instruction_t    instruction_word, out_instr;
    logic            out_valid, out_mismatch, busy, done;
    logic [ErrW-1:0] err_count;

    instruction_t mem [32];
    assign instruction_word = mem[read_pointer];

    always #5 clk = ~clk;

    instr_readback_checker #(.ERR_CNT_W(ErrW)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .first_ptr        (first_ptr),
        .last_ptr         (last_ptr),
        .instruction_word (instruction_word),
        .read_pointer     (read_pointer),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instr        (out_instr),
        .out_addr         (out_addr),
        .out_mismatch     (out_mismatch),
        .busy             (busy),
        .done             (done),
        .err_count        (err_count)
    );

    typedef struct packed {
        address_t     addr;
        instruction_t instr;
        logic         mism;
    } entry_t;

    entry_t exp_q[$];
    int total = 0;
    int bad   = 0;

    function automatic instruction_t mk(opcode_t o, int a, int b, longint r);
        instruction_t w;
        w.opc  = o;
        w.op_a = a;
        w.op_b = b;
        w.res  = r;
        return w;
    endfunction

    task automatic expect_entry(input address_t a, input logic m);
        entry_t e;
        e.addr  = a;
        e.instr = mem[a];
        e.mism  = m;
        exp_q.push_back(e);
    endtask

    task automatic start_pass(input address_t f, input address_t l);
        @(negedge clk);
        first_ptr = f;
        last_ptr  = l;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait; checks the current negedge first.
    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_ptr = '0; last_ptr = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({read_pointer, out_addr, out_instr, out_valid, out_mismatch, busy, done, err_count}
            !== '0) begin
            bad++;
            $display("FAIL reset_state: got ptr=%0d addr=%0d instr=%h v=%b m=%b busy=%b done=%b err=%0d want all 0",
                     read_pointer, out_addr, out_instr, out_valid, out_mismatch, busy, done,
                     err_count);
        end
    endtask

    task automatic test_single();
        bit ok;
        entry_t e;
        out_ready = 1'b1;
        expect_entry(5'd3, 1'b0);
        start_pass(5'd3, 5'd3);
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL single_busy: got %b want 1", busy);
        end
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL single_valid_timeout: got no out_valid want one");
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                bad++;
                $display("FAIL single_entry: got addr=%0d instr=%h m=%b want addr=%0d instr=%h m=%b",
                         out_addr, out_instr, out_mismatch, e.addr, e.instr, e.mism);
            end
        end
        @(negedge clk);
        total++;
        if ({done, out_valid} !== 2'b00) begin
            bad++; $display("FAIL single_early_done: got done=%b v=%b want 0 0", done, out_valid);
        end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b10) begin
            bad++; $display("FAIL single_done_pulse: got done=%b busy=%b want 1 0", done, busy);
        end
        @(negedge clk);
        total++;
        if ({done, out_valid, err_count} !== {2'b00, 2'd0}) begin
            bad++;
            $display("FAIL single_after_done: got done=%b v=%b err=%0d want 0 0 0",
                     done, out_valid, err_count);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        entry_t e;
        mem[30] = mk(SUB, 2, 5, -3);
        mem[31] = mk(DIV, 9, 0, 0);
        mem[0]  = mk(MOD, 7, 3, 1);
        mem[1]  = mk(MULT, -4, 6, -24);
        expect_entry(5'd30, 1'b0);
        expect_entry(5'd31, 1'b0);
        expect_entry(5'd0, 1'b0);
        expect_entry(5'd1, 1'b0);
        out_ready = 1'b1;
        start_pass(5'd30, 5'd1);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL wrap_valid_timeout: got none want entry %0d", k);
            end else begin
                e = exp_q.pop_front();
                if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                    bad++;
                    $display("FAIL wrap_entry: got addr=%0d instr=%h m=%b want addr=%0d instr=%h m=%b",
                             out_addr, out_instr, out_mismatch, e.addr, e.instr, e.mism);
                end
            end
            @(negedge clk);
        end
        wait_done(ok);
        total++;
        if (!ok || err_count !== 2'd0) begin
            bad++; $display("FAIL wrap_done: got done_seen=%b err=%0d want 1 0", ok, err_count);
        end
    endtask

    task automatic test_undef_and_signed();
        bit ok;
        entry_t e;
        mem[10] = mk(opcode_t'(4'hC), 1, 2, 0);
        mem[11] = mk(ZERO, 7, 7, 0);
        mem[12] = mk(PASSA, -9, 4, -9);
        mem[13] = mk(DIV, -7, 2, -3);
        for (int i = 10; i < 14; i++) expect_entry(address_t'(i), 1'b0);
        out_ready = 1'b1;
        start_pass(5'd10, 5'd13);
        for (int k = 0; k < 4; k++) begin
            wait_valid(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL undef_valid_timeout: got none want entry %0d", k);
            end else begin
                e = exp_q.pop_front();
                if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                    bad++;
                    $display("FAIL undef_entry: got addr=%0d m=%b want addr=%0d m=%b",
                             out_addr, out_mismatch, e.addr, e.mism);
                end
            end
            @(negedge clk);
        end
        wait_done(ok);
    endtask

    task automatic test_mismatch();
        bit ok;
        entry_t e;
        logic [ErrW-1:0] exp_err;
        mem[5] = mk(PASSB, 10, 20, 10);
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            exp_err = (p >= 2) ? 2'd3 : ErrW'(p + 1);
            expect_entry(5'd5, 1'b1);
            start_pass(5'd5, 5'd5);
            wait_valid(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL mismatch_valid_timeout: got none want pass %0d", p);
            end else begin
                e = exp_q.pop_front();
                if ({out_addr, out_mismatch, err_count} !== {e.addr, e.mism, exp_err}) begin
                    bad++;
                    $display("FAIL mismatch_pass: got addr=%0d m=%b err=%0d want addr=%0d m=%b err=%0d",
                             out_addr, out_mismatch, err_count, e.addr, e.mism, exp_err);
                end
            end
            @(negedge clk);
            wait_done(ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        entry_t e;
        instruction_t snap;
        mem[20] = mk(ADD, 100, -1, 99);
        mem[21] = mk(SUB, -5, -7, 2);
        expect_entry(5'd20, 1'b0);
        expect_entry(5'd21, 1'b0);
        out_ready = 1'b0;
        start_pass(5'd20, 5'd21);
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_valid_timeout: got none want entry");
        end else begin
            e = exp_q.pop_front();
            if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                bad++;
                $display("FAIL bp_first: got addr=%0d instr=%h want addr=%0d instr=%h",
                         out_addr, out_instr, e.addr, e.instr);
            end
        end
        snap = mem[20];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, out_instr, out_addr, read_pointer} !== {1'b1, snap, 5'd20, 5'd20}) begin
                bad++;
                $display("FAIL bp_hold: got v=%b addr=%0d ptr=%0d instr=%h want 1 20 20 %h",
                         out_valid, out_addr, read_pointer, out_instr, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, read_pointer} !== {1'b0, 5'd21}) begin
            bad++; $display("FAIL bp_gap: got v=%b ptr=%0d want 0 21", out_valid, read_pointer);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_second_valid: got %b want 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            total++;
            if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                bad++;
                $display("FAIL bp_second: got addr=%0d instr=%h want addr=%0d instr=%h",
                         out_addr, out_instr, e.addr, e.instr);
            end
        end
        @(negedge clk);
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL bp_done: got no done want done");
        end
    endtask

    task automatic test_abort();
        bit ok;
        entry_t e;
        out_ready = 1'b0;
        expect_entry(5'd0, 1'b0);
        start_pass(5'd0, 5'd3);
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL abort_valid_timeout: got none want entry");
        end else begin
            e = exp_q.pop_front();
            if ({out_addr, out_instr} !== {e.addr, e.instr}) begin
                bad++;
                $display("FAIL abort_entry: got addr=%0d want %0d", out_addr, e.addr);
            end
        end
        abort = 1'b1; start = 1'b1; first_ptr = 5'd7; last_ptr = 5'd7; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        total++;
        if ({out_valid, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL abort_now: got v=%b busy=%b done=%b want 0 0 0", out_valid, busy, done);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if ({out_valid, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL abort_idle: got v=%b busy=%b done=%b want 0 0 0",
                         out_valid, busy, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        entry_t e;
        total++;
        if (err_count !== 2'd3) begin
            bad++; $display("FAIL rst_pre_err: got %0d want 3", err_count);
        end
        out_ready = 1'b0;
        start_pass(5'd20, 5'd21);
        wait_valid(ok);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({read_pointer, out_addr, out_instr, out_valid, out_mismatch, busy, done, err_count}
            !== '0) begin
            bad++;
            $display("FAIL rst_mid_state: got ptr=%0d addr=%0d v=%b busy=%b done=%b err=%0d want all 0",
                     read_pointer, out_addr, out_valid, busy, done, err_count);
        end
        out_ready = 1'b1;
        expect_entry(5'd3, 1'b0);
        start_pass(5'd3, 5'd3);
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL rst_clean_timeout: got none want entry");
        end else begin
            e = exp_q.pop_front();
            if ({out_addr, out_instr, out_mismatch} !== {e.addr, e.instr, e.mism}) begin
                bad++;
                $display("FAIL rst_clean_entry: got addr=%0d m=%b want addr=%0d m=%b",
                         out_addr, out_mismatch, e.addr, e.mism);
            end
        end
        @(negedge clk);
        wait_done(ok);
        total++;
        if (!ok || err_count !== 2'd0) begin
            bad++; $display("FAIL rst_clean_done: got done_seen=%b err=%0d want 1 0", ok, err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[3] = mk(ADD, 5, 3, 8);
        test_reset();
        test_single();
        test_wrap();
        test_undef_and_signed();
        test_mismatch();
        test_backpressure();
        test_abort();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
